bch_encoder: RTL

BCH_ENCODER -- requirements
Module: bch_encoder

---
 rtl/bch_encoder.sv | 107 ++++++++++
 1 files changed

// File: rtl/bch_encoder.sv
// Systematic BCH encoder: shifts the message through an LFSR divider one bit per
// cycle (MSB first) and presents {message, parity} until downstream accepts it.
module bch_encoder #(
    parameter int unsigned       C_N        = 31,
    parameter int unsigned       C_K        = 11,
    parameter logic [C_N-C_K:0]  C_GEN_POLY = 21'h1626D5
) (
    input  logic           I_clk,
    input  logic           I_rst,
    input  logic [C_K-1:0] I_msg,
    input  logic           I_valid,
    output logic           O_ready,
    output logic [C_N-1:0] O_codeword,
    output logic           O_valid,
    input  logic           I_ready,
    output logic           O_busy
);

    localparam int unsigned P_W   = C_N - C_K;
    localparam int unsigned CNT_W = $clog2(C_K + 1);
    localparam logic [P_W-1:0] GEN_LOW = C_GEN_POLY[P_W-1:0];

    typedef enum logic [1:0] {
        IDLE,
        ENC,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [C_K-1:0]   msg, msg_n;
    logic [P_W-1:0]   par, par_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [C_N-1:0]   codeword_n;
    logic             ready_n, busy_n, valid_n;
    logic             fb;

    // State, datapath and registered outputs
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state      <= IDLE;
            msg        <= '0;
            par        <= '0;
            cnt        <= '0;
            O_codeword <= '0;
            O_ready    <= 1'b1;
            O_busy     <= 1'b0;
            O_valid    <= 1'b0;
        end else begin
            state      <= state_n;
            msg        <= msg_n;
            par        <= par_n;
            cnt        <= cnt_n;
            O_codeword <= codeword_n;
            O_ready    <= ready_n;
            O_busy     <= busy_n;
            O_valid    <= valid_n;
        end
    end

    // Next state, LFSR step and next output values.
    // The message register is rotated each ENC cycle so its MSB is always the
    // next bit; after C_K rotations it is back to the original word.
    always_comb begin
        state_n    = state;
        msg_n      = msg;
        par_n      = par;
        cnt_n      = cnt;
        codeword_n = O_codeword;
        fb         = 1'b0;

        case (state)
            IDLE: begin
                if (I_valid) begin
                    msg_n   = I_msg;
                    par_n   = '0;
                    cnt_n   = '0;
                    state_n = ENC;
                end
            end
            ENC: begin
                fb    = msg[C_K-1] ^ par[P_W-1];
                par_n = {par[P_W-2:0], 1'b0} ^ (fb ? GEN_LOW : '0);
                msg_n = {msg[C_K-2:0], msg[C_K-1]};
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(C_K - 1)) begin
                    state_n    = DONE;
                    codeword_n = {msg_n, par_n};
                end
            end
            DONE: begin
                if (I_ready) begin
                    state_n    = IDLE;
                    codeword_n = '0;
                end
            end
            default: begin
                state_n    = IDLE;
                codeword_n = '0;
            end
        endcase

        ready_n = (state_n == IDLE);
        busy_n  = (state_n == ENC);
        valid_n = (state_n == DONE);
    end

endmodule
